frame_loader: RTL and testbench

Frame-buffer writer for the VGA image path: accepts a framed byte stream of RGB332 pixels and writes it into one of seven 1024-entry image slots in the shared image BRAM (write port A). The display engine reads those slots in row-major block order (address = slot*1024 + j*BLOCKS_WIDE + i). This block produces exactly that layout. It validates each frame with a checksum and reports per-slot load status.

---
 rtl/frame_loader_if.sv | 27 ++
 rtl/frame_loader.sv | 108 ++++++++++
 tb/tb_frame_loader.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/frame_loader_if.sv
// Stream-input and BRAM-write bundle for frame_loader.
// The slave modport is the loader; the master modport is the stream source / BRAM side.
interface frame_loader_if #(
  parameter int NUM_SLOTS = 7
);
  logic [7:0]           in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic                 wr_allow;
  logic [12:0]          bram_addr;
  logic [7:0]           bram_din;
  logic                 bram_we;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic [NUM_SLOTS-1:0] slot_loaded;

  modport master (
    output in_data, in_valid, wr_allow,
    input  in_ready, bram_addr, bram_din, bram_we, busy, done, err, slot_loaded
  );

  modport slave (
    input  in_data, in_valid, wr_allow,
    output in_ready, bram_addr, bram_din, bram_we, busy, done, err, slot_loaded
  );
endinterface

// File: rtl/frame_loader.sv
// Writes a checksummed RGB332 frame stream into one of the image slots of the shared BRAM,
// in row-major order, and tracks which slots hold a verified image.
module frame_loader #(
  parameter int         BLOCKS_WIDE = 32,
  parameter int         BLOCKS_HIGH = 24,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         NUM_SLOTS   = 7
) (
  input  logic            clk,
  input  logic            rst,
  frame_loader_if.slave   bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SLOT  = 2'd1;
  localparam logic [1:0] PIXEL = 2'd2;
  localparam logic [1:0] CHECK = 2'd3;

  localparam int         NUM_PIX     = BLOCKS_WIDE * BLOCKS_HIGH;
  localparam logic [9:0] LAST_PIX    = 10'(NUM_PIX - 1);
  localparam logic [7:0] NUM_SLOTS_B = 8'(NUM_SLOTS);

  logic [1:0]           state;
  logic [2:0]           slot_q;
  logic [9:0]           count_q;
  logic [7:0]           sum_q;
  logic [12:0]          addr_q;
  logic [7:0]           din_q;
  logic                 we_q;
  logic                 done_q;
  logic                 err_q;
  logic [NUM_SLOTS-1:0] loaded_q;
  logic                 ready;
  logic                 accept;

  // Pixel acceptance is held off while the BRAM write window is closed.
  assign ready  = (state == PIXEL) ? bus.wr_allow : 1'b1;
  assign accept = bus.in_valid && ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      slot_q   <= '0;
      count_q  <= '0;
      sum_q    <= '0;
      addr_q   <= '0;
      din_q    <= '0;
      we_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      loaded_q <= '0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      if (accept) begin
        case (state)
          IDLE: begin
            if (bus.in_data == SYNC_BYTE) begin
              state <= SLOT;
              err_q <= 1'b0;
            end
          end
          SLOT: begin
            if (bus.in_data < NUM_SLOTS_B) begin
              slot_q                      <= bus.in_data[2:0];
              loaded_q[bus.in_data[2:0]] <= 1'b0;
              count_q                     <= '0;
              sum_q                       <= '0;
              state                       <= PIXEL;
            end else begin
              err_q <= 1'b1;
              state <= IDLE;
            end
          end
          PIXEL: begin
            // Slot index lands in the top address bits, so slot*1024 needs no multiplier.
            addr_q  <= {slot_q, count_q};
            din_q   <= bus.in_data;
            we_q    <= 1'b1;
            sum_q   <= sum_q + bus.in_data;
            count_q <= count_q + 10'd1;
            if (count_q == LAST_PIX) state <= CHECK;
          end
          CHECK: begin
            if (bus.in_data == sum_q) begin
              loaded_q[slot_q] <= 1'b1;
              done_q           <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.in_ready    = ready;
  assign bus.bram_addr   = addr_q;
  assign bus.bram_din    = din_q;
  assign bus.bram_we     = we_q;
  assign bus.busy        = (state != IDLE);
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.slot_loaded = loaded_q;

endmodule

// File: tb/tb_frame_loader.sv
// Directed-vector bench for frame_loader: expected BRAM writes go into a scoreboard queue
// that a free-running monitor drains whenever the loader asserts bram_we.
module tb_frame_loader;

  typedef struct {
    logic [12:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic clk;
  logic rst;
  frame_loader_if bus ();

  frame_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  wr_t sb[$];
  int  n_checks   = 0;
  int  n_pass     = 0;
  int  writes     = 0;
  int  done_seen  = 0;
  bit  toggle_en  = 0;
  int  allow_cyc  = 0;
  logic prev_allow = 1'b0;
  logic prev_done  = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  // wr_allow changes shortly after the rising edge so it is stable at every falling edge.
  always @(posedge clk) begin
    #2;
    if (toggle_en) begin
      allow_cyc++;
      bus.wr_allow = ((allow_cyc / 4) % 2) == 0;
    end else begin
      bus.wr_allow = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (bus.bram_we) begin
      writes++;
      checkOutput("we_after_allow", {31'd0, prev_allow}, 32'd1);
      checkOutput("write_expected", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        wr_t e;
        e = sb.pop_front();
        checkOutput("write_addr_data", {11'd0, bus.bram_addr, bus.bram_din},
                    {11'd0, e.addr, e.data});
      end
    end
    if (bus.done) begin
      done_seen++;
      checkOutput("done_one_cycle", {31'd0, prev_done}, 32'd0);
    end
    prev_allow = bus.wr_allow;
    prev_done  = bus.done;
  end

  task automatic applyStimulus(input logic [7:0] b);
    int tries = 0;
    @(negedge clk);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && tries < 200) begin
      @(negedge clk);
      tries++;
    end
    if (!bus.in_ready) checkOutput("accept_timeout", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
  endtask

  task automatic settle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
  endtask

  function automatic logic [7:0] pix(input int mode, input int k);
    case (mode)
      0:       return 8'(k);
      1:       return 8'h01;
      2:       return 8'h02;
      3:       return 8'(k * 3);
      default: return (k == 10) ? 8'hA5 : 8'(k + 7);
    endcase
  endfunction

  task automatic sendFrame(input int slot, input int mode, input logic [7:0] csum);
    applyStimulus(8'hA5);
    applyStimulus(8'(slot));
    for (int k = 0; k < 768; k++) begin
      wr_t e;
      e.addr = 13'(slot * 1024 + k);
      e.data = pix(mode, k);
      sb.push_back(e);
      applyStimulus(e.data);
    end
    applyStimulus(csum);
    settle();
  endtask

  initial begin
    rst          = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    bus.wr_allow = 1'b1;
    #12;
    checkOutput("rst_busy",   {31'd0, bus.busy}, 32'd0);
    checkOutput("rst_done",   {31'd0, bus.done}, 32'd0);
    checkOutput("rst_err",    {31'd0, bus.err}, 32'd0);
    checkOutput("rst_we",     {31'd0, bus.bram_we}, 32'd0);
    checkOutput("rst_addr",   {19'd0, bus.bram_addr}, 32'd0);
    checkOutput("rst_din",    {24'd0, bus.bram_din}, 32'd0);
    checkOutput("rst_loaded", {25'd0, bus.slot_loaded}, 32'd0);
    checkOutput("rst_ready",  {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b1;

    $display("[TB] slot 0 ramp frame");
    writes = 0;
    sendFrame(0, 0, 8'h80);
    checkOutput("t1_writes", writes, 32'd768);
    checkOutput("t1_done",   done_seen, 32'd1);
    checkOutput("t1_loaded", {25'd0, bus.slot_loaded}, 32'b0000001);
    checkOutput("t1_err",    {31'd0, bus.err}, 32'd0);
    checkOutput("t1_busy",   {31'd0, bus.busy}, 32'd0);

    $display("[TB] slot 3 frame with wr_allow toggling");
    toggle_en = 1;
    writes    = 0;
    sendFrame(3, 1, 8'h00);
    toggle_en = 0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("t2_writes", writes, 32'd768);
    checkOutput("t2_done",   done_seen, 32'd2);
    checkOutput("t2_loaded", {25'd0, bus.slot_loaded}, 32'b0001001);

    $display("[TB] slot 5 frame with bad checksum");
    writes = 0;
    sendFrame(5, 2, 8'h55);
    checkOutput("t3_writes", writes, 32'd768);
    checkOutput("t3_done",   done_seen, 32'd2);
    checkOutput("t3_err",    {31'd0, bus.err}, 32'd1);
    checkOutput("t3_loaded", {25'd0, bus.slot_loaded}, 32'b0001001);
    applyStimulus(8'hA5);
    settle();
    checkOutput("t3_sync_clears_err", {31'd0, bus.err}, 32'd0);
    checkOutput("t3_sync_busy",       {31'd0, bus.busy}, 32'd1);
    applyStimulus(8'h07);
    settle();
    checkOutput("t3_badslot_err", {31'd0, bus.err}, 32'd1);

    $display("[TB] junk then invalid slot");
    writes = 0;
    applyStimulus(8'h00);
    applyStimulus(8'h12);
    settle();
    checkOutput("t4_junk_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("t4_junk_err",  {31'd0, bus.err}, 32'd1);
    applyStimulus(8'hA5);
    settle();
    checkOutput("t4_sync_busy", {31'd0, bus.busy}, 32'd1);
    checkOutput("t4_sync_err",  {31'd0, bus.err}, 32'd0);
    applyStimulus(8'h07);
    settle();
    checkOutput("t4_err",    {31'd0, bus.err}, 32'd1);
    checkOutput("t4_busy",   {31'd0, bus.busy}, 32'd0);
    checkOutput("t4_writes", writes, 32'd0);

    $display("[TB] slot 2 load, reload, reset mid-frame");
    sendFrame(2, 3, 8'h80);
    checkOutput("t5_done",   done_seen, 32'd3);
    checkOutput("t5_loaded", {25'd0, bus.slot_loaded}, 32'b0001101);
    checkOutput("t5_err",    {31'd0, bus.err}, 32'd0);
    applyStimulus(8'hA5);
    applyStimulus(8'h02);
    settle();
    checkOutput("t5_reload_clears", {25'd0, bus.slot_loaded}, 32'b0001001);
    for (int k = 0; k < 100; k++) begin
      wr_t e;
      e.addr = 13'(2 * 1024 + k);
      e.data = pix(3, k);
      sb.push_back(e);
      applyStimulus(e.data);
    end
    settle();
    checkOutput("t5_partial_drained", sb.size(), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("t5_rst_busy",   {31'd0, bus.busy}, 32'd0);
    checkOutput("t5_rst_we",     {31'd0, bus.bram_we}, 32'd0);
    checkOutput("t5_rst_loaded", {25'd0, bus.slot_loaded}, 32'd0);
    @(negedge clk);
    rst    = 1'b1;
    writes = 0;
    for (int k = 0; k < 20; k++) applyStimulus(8'h11);
    settle();
    checkOutput("t5_post_busy",   {31'd0, bus.busy}, 32'd0);
    checkOutput("t5_post_writes", writes, 32'd0);

    $display("[TB] slot 1 frame with sync value as pixel");
    writes = 0;
    sendFrame(1, 4, 8'h14);
    checkOutput("t6_writes", writes, 32'd768);
    checkOutput("t6_done",   done_seen, 32'd4);
    checkOutput("t6_loaded", {25'd0, bus.slot_loaded}, 32'b0000010);
    checkOutput("t6_err",    {31'd0, bus.err}, 32'd0);

    repeat (3) @(negedge clk);
    checkOutput("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

endmodule
